eae_divide_unit: RTL and testbench

- Iterative restoring divider executing the PDP-8 EAE DVI operation.
- Divides the 24-bit dividend AC:MQ by a 12-bit divisor: quotient to MQ, remainder to AC, divide-overflow to link.
- Sits directly downstream of the EAE control block, which issues the start pulse and latches the divide results into ac_dvi/mq_dvi/link_dvi.
- One quotient bit is produced per clock.

---
 rtl/eae_divide_unit.sv | 96 +++++++++
 tb/tb_eae_divide_unit.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/eae_divide_unit.sv
// PDP-8 EAE DVI: restoring divide of AC:MQ by a WIDTH-bit divisor, one quotient bit per clock.
// Quotient lands in mq_dvi, remainder in ac_dvi, divide overflow in link_dvi.
module eae_divide_unit #(
    parameter int WIDTH = 12
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] ac_in,
    input  logic [WIDTH-1:0] mq_in,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] ac_dvi,
    output logic [WIDTH-1:0] mq_dvi,
    output logic             link_dvi
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, DIVIDE, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] d;
    logic [CW-1:0]    count;

    logic [WIDTH:0]   r_sh;
    logic             step_ge;
    logic [WIDTH-1:0] r_nx;
    logic [WIDTH-1:0] q_nx;

    // The partial remainder always stays below D, so only the shifted value needs the extra bit.
    always_comb begin
        r_sh    = {r, q[WIDTH-1]};
        step_ge = (r_sh >= {1'b0, d});
        r_nx    = step_ge ? WIDTH'(r_sh - {1'b0, d}) : r_sh[WIDTH-1:0];
        q_nx    = {q[WIDTH-2:0], step_ge};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            ac_dvi   <= '0;
            mq_dvi   <= '0;
            link_dvi <= 1'b0;
            r        <= '0;
            q        <= '0;
            d        <= '0;
            count    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        // AC >= divisor means the quotient cannot fit; also catches divide by zero.
                        if (ac_in >= divisor) begin
                            ac_dvi   <= ac_in;
                            mq_dvi   <= mq_in;
                            link_dvi <= 1'b1;
                            done     <= 1'b1;
                            state    <= DONE;
                        end else begin
                            r     <= ac_in;
                            q     <= mq_in;
                            d     <= divisor;
                            count <= '0;
                            busy  <= 1'b1;
                            state <= DIVIDE;
                        end
                    end
                end
                DIVIDE: begin
                    r     <= r_nx;
                    q     <= q_nx;
                    count <= count + 1'b1;
                    if (count == LAST) begin
                        ac_dvi   <= r_nx;
                        mq_dvi   <= q_nx;
                        link_dvi <= 1'b0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_eae_divide_unit.sv
// Directed bench for eae_divide_unit: vector table plus ignored-start and mid-divide reset sequences.
module tb_eae_divide_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [11:0] ac_in, mq_in, divisor;
    logic        busy, done, link_dvi;
    logic [11:0] ac_dvi, mq_dvi;

    int n_chk = 0;
    int n_fail = 0;

    eae_divide_unit #(.WIDTH(12)) dut (
        .clock(clock), .reset(reset), .start(start),
        .ac_in(ac_in), .mq_in(mq_in), .divisor(divisor),
        .busy(busy), .done(done),
        .ac_dvi(ac_dvi), .mq_dvi(mq_dvi), .link_dvi(link_dvi)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [11:0] ac, mq, dv;
        logic [11:0] exp_ac, exp_mq;
        logic        exp_link;
        int          exp_lat;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Caller is #1 after an edge; start is sampled on the next edge.
    task automatic run_one(input vec_t v, input string tag);
        int lat, bcnt, both;
        bit seen;
        ac_in = v.ac; mq_in = v.mq; divisor = v.dv; start = 1'b1;
        tick();
        start = 1'b0;
        lat = 0; bcnt = 0; both = 0; seen = 0;
        for (int k = 1; k <= 30 && !seen; k++) begin
            if (busy) bcnt++;
            if (busy && done) both++;
            if (done) begin
                seen = 1'b1;
                lat  = k;
            end else begin
                tick();
            end
        end
        chk({tag, " latency"}, lat, v.exp_lat);
        chk({tag, " busy_cycles"}, bcnt, v.exp_lat - 1);
        chk({tag, " busy_and_done"}, both, 0);
        chk({tag, " ac_dvi"}, int'(ac_dvi), int'(v.exp_ac));
        chk({tag, " mq_dvi"}, int'(mq_dvi), int'(v.exp_mq));
        chk({tag, " link_dvi"}, int'(link_dvi), int'(v.exp_link));
    endtask

    initial begin
        int lat, seen;
        vecs[0] = '{12'd0,     12'd100,   12'd7,     12'd2,     12'd14,    1'b0, 13};
        vecs[1] = '{12'd1,     12'd0,     12'd64,    12'd0,     12'd64,    1'b0, 13};
        vecs[2] = '{12'd5,     12'o1234,  12'd5,     12'd5,     12'o1234,  1'b1, 1};
        vecs[3] = '{12'd0,     12'h123,   12'd0,     12'd0,     12'h123,   1'b1, 1};
        vecs[4] = '{12'hFFE,   12'hFFF,   12'hFFF,   12'hFFE,   12'hFFF,   1'b0, 13};
        vecs[5] = '{12'h123,   12'h456,   12'h200,   12'h056,   12'h91A,   1'b0, 13};

        reset = 1'b1; start = 1'b0; ac_in = '0; mq_in = '0; divisor = '0;
        tick(); tick();
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        chk("reset ac_dvi", int'(ac_dvi), 0);
        chk("reset mq_dvi", int'(mq_dvi), 0);
        chk("reset link_dvi", int'(link_dvi), 0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) begin
            run_one(vecs[i], $sformatf("vec%0d", i));
            tick();
            chk($sformatf("vec%0d done_single_pulse", i), int'(done), 0);
        end

        // Second start during DIVIDE with different operands must be ignored.
        ac_in = 12'd0; mq_in = 12'd100; divisor = 12'd7; start = 1'b1;
        tick();
        start = 1'b0;
        lat = 0; seen = 0;
        for (int k = 1; k <= 30 && seen == 0; k++) begin
            if (k == 4) begin
                ac_in = 12'd1; mq_in = 12'd50; divisor = 12'd3; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                seen = 1;
                lat  = k;
            end else begin
                tick();
            end
        end
        start = 1'b0;
        chk("ignore latency", lat, 13);
        chk("ignore ac_dvi", int'(ac_dvi), 2);
        chk("ignore mq_dvi", int'(mq_dvi), 14);
        chk("ignore link_dvi", int'(link_dvi), 0);
        tick();
        run_one(vecs[5], "b2b");

        // Reset in the middle of a divide: outputs clear, no done follows.
        tick();
        ac_in = 12'd0; mq_in = 12'd100; divisor = 12'd7; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick(); tick();
        chk("midrst busy_before", int'(busy), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst busy", int'(busy), 0);
        chk("midrst done", int'(done), 0);
        chk("midrst ac_dvi", int'(ac_dvi), 0);
        chk("midrst mq_dvi", int'(mq_dvi), 0);
        chk("midrst link_dvi", int'(link_dvi), 0);
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            if (done || busy) seen++;
            tick();
        end
        chk("midrst no_done", seen, 0);

        // start together with reset is dropped.
        ac_in = 12'd0; mq_in = 12'd9; divisor = 12'd2; start = 1'b1; reset = 1'b1;
        tick();
        start = 1'b0; reset = 1'b0;
        chk("rst_start busy", int'(busy), 0);
        tick();
        chk("rst_start done", int'(done), 0);
        chk("rst_start busy2", int'(busy), 0);

        run_one(vecs[0], "post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
